mem_access_unit: RTL

- MEM-stage load/store engine of the 32-bit LoongArch pipeline; sits between the EX/MEM register and the MEM/WB register.
- Issues data-bus requests and holds the pipeline until each access completes.
- Aligns and extends load data, then presents a complete MEM/WB input bundle (PC, inst, ctrl, rs, cal_res, data) each cycle.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues data-bus accesses, aligns/extends load data, forms the MEM/WB bundle.
// Latency: non-memory ops pass through in the same cycle; memory ops stall until the bus completes, then present one DONE cycle.
module mem_access_unit #(
    parameter int WORD    = 32,
    parameter int REG_LOG = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic [WORD-1:0]        ex_pc,
    input  logic [WORD-1:0]        ex_inst,
    input  logic [7:0]             ex_ctrl,
    input  logic [REG_LOG*3-1:0]   ex_rs,
    input  logic [WORD-1:0]        ex_cal_res,
    input  logic [WORD-1:0]        ex_st_data,
    input  logic [3:0]             ex_mem_op,
    input  logic                   flush,
    output logic                   dbus_req,
    output logic                   dbus_we,
    output logic [WORD-1:0]        dbus_addr,
    output logic [3:0]             dbus_wstrb,
    output logic [WORD-1:0]        dbus_wdata,
    input  logic                   dbus_gnt,
    input  logic                   dbus_rvalid,
    input  logic [WORD-1:0]        dbus_rdata,
    output logic                   mem_stall,
    output logic                   mem_ale,
    output logic                   wb_valid,
    output logic [WORD-1:0]        wb_pc,
    output logic [WORD-1:0]        wb_inst,
    output logic [7:0]             wb_ctrl,
    output logic [REG_LOG*3-1:0]   wb_rs,
    output logic [WORD-1:0]        wb_cal_res,
    output logic [WORD-1:0]        wb_data
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]      state, state_nxt;
    logic [WORD-1:0] ld_data;
    logic            is_load, is_store, ld_uns, sz_b, sz_h, sz_w;
    logic            mem_op, misaligned, go, capture;
    logic [1:0]      a;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [WORD-1:0] ld_ext;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        ld_uns   = 1'b0;
        sz_b     = 1'b0;
        sz_h     = 1'b0;
        sz_w     = 1'b0;
        case (ex_mem_op)
            4'd1: begin is_load = 1'b1; sz_b = 1'b1; end
            4'd2: begin is_load = 1'b1; sz_h = 1'b1; end
            4'd3: begin is_load = 1'b1; sz_w = 1'b1; end
            4'd4: begin is_load = 1'b1; sz_b = 1'b1; ld_uns = 1'b1; end
            4'd5: begin is_load = 1'b1; sz_h = 1'b1; ld_uns = 1'b1; end
            4'd6: begin is_store = 1'b1; sz_b = 1'b1; end
            4'd7: begin is_store = 1'b1; sz_h = 1'b1; end
            4'd8: begin is_store = 1'b1; sz_w = 1'b1; end
            default: ;
        endcase
    end

    assign a          = ex_cal_res[1:0];
    assign mem_op     = is_load | is_store;
    assign misaligned = (sz_h & a[0]) | (sz_w & (|a));
    assign go         = ex_valid & ~flush & mem_op & ~misaligned;

    assign byte_sel = dbus_rdata[{a, 3'b000} +: 8];
    assign half_sel = dbus_rdata[{a[1], 4'b0000} +: 16];
    assign ld_ext   = sz_b ? {{(WORD-8){~ld_uns & byte_sel[7]}}, byte_sel} :
                      sz_h ? {{(WORD-16){~ld_uns & half_sel[15]}}, half_sel} :
                             dbus_rdata;

    // A flushed load still owes us one rvalid; DRAIN swallows it unless it has already arrived.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:  if (go) state_nxt = REQ;
            REQ: begin
                if (dbus_gnt) begin
                    if (flush)
                        state_nxt = (is_store | dbus_rvalid) ? IDLE : DRAIN;
                    else if (is_store)
                        state_nxt = DONE;
                    else if (dbus_rvalid) begin
                        state_nxt = DONE;
                        capture   = 1'b1;
                    end else
                        state_nxt = WAIT;
                end else if (flush)
                    state_nxt = IDLE;
            end
            WAIT: begin
                if (flush)
                    state_nxt = dbus_rvalid ? IDLE : DRAIN;
                else if (dbus_rvalid) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end
            end
            DRAIN: if (dbus_rvalid) state_nxt = IDLE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ld_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && go)
                ld_data <= '0;
            else if (capture)
                ld_data <= ld_ext;
        end
    end

    assign dbus_req   = rst & (state == REQ);
    assign dbus_we    = is_store;
    assign dbus_addr  = {ex_cal_res[WORD-1:2], 2'b00};
    assign dbus_wstrb = sz_w ? 4'b1111 :
                        sz_h ? (a[1] ? 4'b1100 : 4'b0011) :
                        sz_b ? (4'b0001 << a) : 4'b0000;
    assign dbus_wdata = sz_b ? {(WORD/8){ex_st_data[7:0]}} :
                        sz_h ? {(WORD/16){ex_st_data[15:0]}} : ex_st_data;

    assign mem_stall = rst & ((state == REQ) | (state == WAIT) | (state == DRAIN) |
                              ((state == IDLE) & go));
    assign mem_ale   = rst & (state == IDLE) & ex_valid & mem_op & misaligned;
    assign wb_valid  = rst & (((state == IDLE) & ex_valid & ~flush & ~(mem_op & ~misaligned)) |
                              ((state == DONE) & ~flush));
    assign wb_data   = (state == DONE) ? ld_data : '0;

    assign wb_pc      = ex_pc;
    assign wb_inst    = ex_inst;
    assign wb_ctrl    = ex_ctrl;
    assign wb_rs      = ex_rs;
    assign wb_cal_res = ex_cal_res;

endmodule
